// File: rtl/alu_div_sequencer_pkg.sv
// Shared definitions for the multi-cycle divide sequencer: ALU opcode,
// RISC-V divide operation encodings and the sequencer state type.
package alu_div_sequencer_pkg;

  localparam int DIV_WIDTH  = 32;
  localparam int DIV_ITER_W = 5;

  // ALU opcode for add; with i_AluOpAlt=1 the ALU subtracts.
  localparam logic [2:0] ALUOP_ADD = 3'b000;

  // funct3[1:0] of the M-extension divide instructions.
  localparam logic [1:0] DIVOP_DIV  = 2'b00;
  localparam logic [1:0] DIVOP_DIVU = 2'b01;
  localparam logic [1:0] DIVOP_REM  = 2'b10;
  localparam logic [1:0] DIVOP_REMU = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    NEG_A,
    NEG_B,
    CMP,
    ITER,
    FIX,
    DONE
  } div_state_t;

endpackage

// File: rtl/alu_div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU controller that borrows the shared ALU.
// Restoring radix-2 division, one ALU subtract per quotient bit; operands are
// converted to magnitudes first and the selected result is re-signed at the end.
// Optional feature: define DIV_EARLY_OUT_EN to add a CMP state that finishes
// early when |dividend| < |divisor|.
module alu_div_sequencer
  import alu_div_sequencer_pkg::*;
#(
  parameter int WIDTH  = DIV_WIDTH,
  parameter int ITER_W = DIV_ITER_W
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic               i_Valid,
  output logic               o_Ready,
  input  logic [1:0]         i_Op,
  input  logic [WIDTH-1:0]   i_Dividend,
  input  logic [WIDTH-1:0]   i_Divisor,
  input  logic               i_Kill,
  output logic               o_Done,
  output logic [WIDTH-1:0]   o_Result,
  output logic               o_AluOwn,
  output logic [2:0]         o_AluOp,
  output logic               o_AluOpAlt,
  output logic [WIDTH-1:0]   o_AluSource1,
  output logic [WIDTH-1:0]   o_AluSource2,
  input  logic [WIDTH-1:0]   i_AluOutput,
  input  logic               i_AluLessThanUnsigned
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t state, nextState;

  // qReg holds the dividend, then |A|, then the quotient as it shifts in.
  logic [WIDTH-1:0]  qReg;
  logic [WIDTH-1:0]  rReg;
  logic [WIDTH-1:0]  bReg;
  logic [ITER_W-1:0] iterCnt;
  logic              aNeg;
  logic              bNeg;
  logic              isRem;

  logic              isSignedOp;
  logic              isRemOp;
  logic              divByZero;
  logic              signedOverflow;
  logic              special;
  logic              accept;
  logic [WIDTH-1:0]  specialResult;
  logic [WIDTH-1:0]  shifted;
  logic              carry;
  logic              takeSub;
  logic [WIDTH-1:0]  fixValue;
  logic              fixNeg;

  assign isSignedOp     = (i_Op == DIVOP_DIV) || (i_Op == DIVOP_REM);
  assign isRemOp        = (i_Op == DIVOP_REM) || (i_Op == DIVOP_REMU);
  assign divByZero      = (i_Divisor == '0);
  assign signedOverflow = isSignedOp && (i_Dividend == MIN_NEG) && (i_Divisor == '1);
  assign special        = divByZero || signedOverflow;
  assign accept         = i_Valid && (state == IDLE) && !i_Kill;

  // Corner cases answered directly at accept without touching the ALU.
  assign specialResult = isRemOp ? (divByZero ? i_Dividend : '0)
                                 : (divByZero ? '1 : MIN_NEG);

  // Partial remainder shifted left with the next dividend bit; carry is bit 32.
  assign shifted = {rReg[WIDTH-2:0], qReg[WIDTH-1]};
  assign carry   = rReg[WIDTH-1];
  assign takeSub = carry || !i_AluLessThanUnsigned;

  assign fixValue = isRem ? rReg : qReg;
  assign fixNeg   = isRem ? aNeg : (aNeg ^ bNeg);

  assign o_Ready = (state == IDLE);
  // A kill landing in DONE must swallow the completion pulse in the same cycle.
  assign o_Done  = (state == DONE) && !i_Kill;

  // Next-state and ALU operand selection.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    nextState    = state;
    o_AluOwn     = 1'b0;
    o_AluSource1 = '0;
    o_AluSource2 = '0;
    case (state)
      IDLE: begin
        if (accept) nextState = special ? DONE : NEG_A;
      end
      NEG_A: begin
        o_AluOwn     = 1'b1;
        o_AluSource2 = qReg;
        nextState    = NEG_B;
      end
      NEG_B: begin
        o_AluOwn     = 1'b1;
        o_AluSource2 = bReg;
`ifdef DIV_EARLY_OUT_EN
        nextState    = CMP;
`else
        nextState    = ITER;
`endif
      end
`ifdef DIV_EARLY_OUT_EN
      CMP: begin
        o_AluOwn     = 1'b1;
        o_AluSource1 = qReg;
        o_AluSource2 = bReg;
        nextState    = i_AluLessThanUnsigned ? FIX : ITER;
      end
`endif
      ITER: begin
        o_AluOwn     = 1'b1;
        o_AluSource1 = shifted;
        o_AluSource2 = bReg;
        if (iterCnt == '1) nextState = FIX;
      end
      FIX: begin
        o_AluOwn     = 1'b1;
        o_AluSource2 = fixValue;
        nextState    = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (i_Kill && (state != IDLE)) nextState = IDLE;
  end

  // The sequencer only ever subtracts; ALU controls are zero when not owned.
  assign o_AluOp    = o_AluOwn ? ALUOP_ADD : 3'b000;
  assign o_AluOpAlt = o_AluOwn;

  // State register and datapath updates.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state    <= IDLE;
      qReg     <= '0;
      rReg     <= '0;
      bReg     <= '0;
      iterCnt  <= '0;
      aNeg     <= 1'b0;
      bNeg     <= 1'b0;
      isRem    <= 1'b0;
      o_Result <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, e.g. the ITER update reads the old qReg and rReg.
      state <= nextState;
      case (state)
        IDLE: begin
          if (accept) begin
            qReg    <= i_Dividend;
            bReg    <= i_Divisor;
            rReg    <= '0;
            iterCnt <= '0;
            aNeg    <= isSignedOp && i_Dividend[WIDTH-1];
            bNeg    <= isSignedOp && i_Divisor[WIDTH-1];
            isRem   <= isRemOp;
            if (special) o_Result <= specialResult;
          end
        end
        NEG_A: if (aNeg) qReg <= i_AluOutput;
        NEG_B: if (bNeg) bReg <= i_AluOutput;
`ifdef DIV_EARLY_OUT_EN
        CMP: begin
          if (i_AluLessThanUnsigned) begin
            rReg <= qReg;
            qReg <= '0;
          end
        end
`endif
        ITER: begin
          rReg    <= takeSub ? i_AluOutput : shifted;
          qReg    <= {qReg[WIDTH-2:0], takeSub};
          iterCnt <= iterCnt + ITER_W'(1);
        end
        FIX: begin
          if (!i_Kill) o_Result <= fixNeg ? i_AluOutput : fixValue;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Directed testbench for alu_div_sequencer with a behavioural model of the
// shared ALU (subtract plus unsigned less-than). Honours DIV_EARLY_OUT_EN.
module tb_alu_div_sequencer;
  import alu_div_sequencer_pkg::*;

`ifdef DIV_EARLY_OUT_EN
  localparam int NORMAL_LAT = 37;
  localparam int SMALL_LAT  = 5;
`else
  localparam int NORMAL_LAT = 36;
  localparam int SMALL_LAT  = 36;
`endif
  localparam int SPECIAL_LAT = 1;

  logic        i_Clock;
  logic        i_Reset;
  logic        i_Valid;
  logic        o_Ready;
  logic [1:0]  i_Op;
  logic [31:0] i_Dividend;
  logic [31:0] i_Divisor;
  logic        i_Kill;
  logic        o_Done;
  logic [31:0] o_Result;
  logic        o_AluOwn;
  logic [2:0]  o_AluOp;
  logic        o_AluOpAlt;
  logic [31:0] o_AluSource1;
  logic [31:0] o_AluSource2;
  logic [31:0] i_AluOutput;
  logic        i_AluLessThanUnsigned;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expResult;
    int          expLat;
  } vec_t;

  alu_div_sequencer dut (
    .i_Clock               (i_Clock),
    .i_Reset               (i_Reset),
    .i_Valid               (i_Valid),
    .o_Ready               (o_Ready),
    .i_Op                  (i_Op),
    .i_Dividend            (i_Dividend),
    .i_Divisor             (i_Divisor),
    .i_Kill                (i_Kill),
    .o_Done                (o_Done),
    .o_Result              (o_Result),
    .o_AluOwn              (o_AluOwn),
    .o_AluOp               (o_AluOp),
    .o_AluOpAlt            (o_AluOpAlt),
    .o_AluSource1          (o_AluSource1),
    .o_AluSource2          (o_AluSource2),
    .i_AluOutput           (i_AluOutput),
    .i_AluLessThanUnsigned (i_AluLessThanUnsigned)
  );

  // Shared ALU as seen by the sequencer: always a subtract.
  assign i_AluOutput           = o_AluSource1 - o_AluSource2;
  assign i_AluLessThanUnsigned = o_AluSource1 < o_AluSource2;

  initial begin
    i_Clock = 1'b0;
    forever #5 i_Clock = ~i_Clock;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issues one request and waits (bounded) for o_Done; doneCyc=0 means timeout.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int doneCyc, output logic [31:0] result,
                        output logic sawOwn, output logic badCtrl, output logic readyAtDone);
    doneCyc     = 0;
    result      = '0;
    sawOwn      = 1'b0;
    badCtrl     = 1'b0;
    readyAtDone = 1'b0;
    @(negedge i_Clock);
    i_Valid    = 1'b1;
    i_Op       = op;
    i_Dividend = a;
    i_Divisor  = b;
    @(posedge i_Clock);
    #1 i_Valid = 1'b0;
    for (int cyc = 1; cyc <= 60 && doneCyc == 0; cyc++) begin
      @(negedge i_Clock);
      if (o_AluOwn === 1'b1) begin
        sawOwn = 1'b1;
        if (o_AluOp !== ALUOP_ADD || o_AluOpAlt !== 1'b1) badCtrl = 1'b1;
      end
      if (o_Done === 1'b1) begin
        doneCyc     = cyc;
        result      = o_Result;
        readyAtDone = o_Ready;
      end
    end
  endtask

  task automatic test_reset();
    i_Reset = 1'b1;
    repeat (3) @(posedge i_Clock);
    #1 i_Reset = 1'b0;
    @(negedge i_Clock);
    checks++;
    if (o_Ready !== 1'b1 || o_Done !== 1'b0 || o_AluOwn !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b done=%b own=%b, required 1 0 0", o_Ready, o_Done, o_AluOwn);
    end
    checks++;
    if (o_Result !== 32'h0) begin
      errors++;
      $display("FAIL reset_result: got %h, required 00000000", o_Result);
    end
    checks++;
    if (o_AluSource1 !== 32'h0 || o_AluSource2 !== 32'h0 || o_AluOpAlt !== 1'b0 || o_AluOp !== 3'b000) begin
      errors++;
      $display("FAIL reset_alu: src1=%h src2=%h op=%b alt=%b, required all zero",
               o_AluSource1, o_AluSource2, o_AluOp, o_AluOpAlt);
    end
  endtask

  task automatic test_divide();
    vec_t v [14] = '{
      '{DIVOP_DIVU, 32'd100,        32'd7,          32'd14,         NORMAL_LAT},
      '{DIVOP_REMU, 32'd100,        32'd7,          32'd2,          NORMAL_LAT},
      '{DIVOP_DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   NORMAL_LAT},
      '{DIVOP_REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   NORMAL_LAT},
      '{DIVOP_REM,  32'd7,          32'hFFFFFFFE,   32'd1,          NORMAL_LAT},
      '{DIVOP_DIV,  32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          NORMAL_LAT},
      '{DIVOP_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   NORMAL_LAT},
      '{DIVOP_DIVU, 32'hFFFFFFFF,   32'h80000001,   32'd1,          NORMAL_LAT},
      '{DIVOP_REMU, 32'hFFFFFFFF,   32'h80000001,   32'h7FFFFFFE,   NORMAL_LAT},
      '{DIVOP_DIV,  32'h80000000,   32'd2,          32'hC0000000,   NORMAL_LAT},
      '{DIVOP_DIVU, 32'h80000000,   32'hFFFFFFFF,   32'd0,          SMALL_LAT},
      '{DIVOP_DIVU, 32'd3,          32'd10,         32'd0,          SMALL_LAT},
      '{DIVOP_REMU, 32'd3,          32'd10,         32'd3,          SMALL_LAT},
      '{DIVOP_REM,  32'hFFFFFFFD,   32'd10,         32'hFFFFFFFD,   SMALL_LAT}
    };
    int          doneCyc;
    logic [31:0] result;
    logic        sawOwn, badCtrl, readyAtDone;
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, doneCyc, result, sawOwn, badCtrl, readyAtDone);
      checks++;
      if (doneCyc != v[i].expLat) begin
        errors++;
        $display("FAIL divide_latency op=%b a=%h b=%h: done at c%0d, required c%0d",
                 v[i].op, v[i].a, v[i].b, doneCyc, v[i].expLat);
      end
      checks++;
      if (result !== v[i].expResult) begin
        errors++;
        $display("FAIL divide_result op=%b a=%h b=%h: got %h, required %h",
                 v[i].op, v[i].a, v[i].b, result, v[i].expResult);
      end
      checks++;
      if (badCtrl !== 1'b0 || sawOwn !== 1'b1 || readyAtDone !== 1'b0) begin
        errors++;
        $display("FAIL divide_ctrl op=%b a=%h b=%h: badCtrl=%b sawOwn=%b readyAtDone=%b, required 0 1 0",
                 v[i].op, v[i].a, v[i].b, badCtrl, sawOwn, readyAtDone);
      end
    end
  endtask

  task automatic test_special();
    vec_t v [6] = '{
      '{DIVOP_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, SPECIAL_LAT},
      '{DIVOP_REMU, 32'd5,        32'd0,        32'd5,        SPECIAL_LAT},
      '{DIVOP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPECIAL_LAT},
      '{DIVOP_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        SPECIAL_LAT},
      '{DIVOP_DIV,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, SPECIAL_LAT},
      '{DIVOP_REM,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, SPECIAL_LAT}
    };
    int          doneCyc;
    logic [31:0] result;
    logic        sawOwn, badCtrl, readyAtDone;
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, doneCyc, result, sawOwn, badCtrl, readyAtDone);
      checks++;
      if (doneCyc != v[i].expLat || result !== v[i].expResult) begin
        errors++;
        $display("FAIL special op=%b a=%h b=%h: c%0d result %h, required c%0d result %h",
                 v[i].op, v[i].a, v[i].b, doneCyc, result, v[i].expLat, v[i].expResult);
      end
      checks++;
      if (sawOwn !== 1'b0) begin
        errors++;
        $display("FAIL special_alu_own op=%b a=%h b=%h: o_AluOwn seen high, required never", v[i].op, v[i].a, v[i].b);
      end
    end
  endtask

  // Kill at c10 of a long op, then a fresh DIVU 9/3 accepted at c11.
  task automatic test_kill(input logic [31:0] heldResult);
    logic sawDone = 1'b0;
    int   doneCyc = 0;
    logic [31:0] result = '0;
    @(negedge i_Clock);
    i_Valid = 1'b1; i_Op = DIVOP_DIVU; i_Dividend = 32'd100; i_Divisor = 32'd7;
    @(posedge i_Clock);
    #1 i_Valid = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge i_Clock);
      if (o_Done === 1'b1) sawDone = 1'b1;
      if (cyc == 10) i_Kill = 1'b1;
    end
    @(posedge i_Clock);
    #1 i_Kill = 1'b0;
    @(negedge i_Clock);
    if (o_Done === 1'b1) sawDone = 1'b1;
    checks++;
    if (o_Ready !== 1'b1 || sawDone !== 1'b0) begin
      errors++;
      $display("FAIL kill_abort: ready at c11=%b sawDone=%b, required 1 0", o_Ready, sawDone);
    end
    checks++;
    if (o_Result !== heldResult) begin
      errors++;
      $display("FAIL kill_hold: o_Result %h, required %h", o_Result, heldResult);
    end
    i_Valid = 1'b1; i_Op = DIVOP_DIVU; i_Dividend = 32'd9; i_Divisor = 32'd3;
    @(posedge i_Clock);
    #1 i_Valid = 1'b0;
    for (int cyc = 12; cyc <= 80 && doneCyc == 0; cyc++) begin
      @(negedge i_Clock);
      if (o_Done === 1'b1) begin
        doneCyc = cyc;
        result  = o_Result;
      end
    end
    checks++;
    if (doneCyc != 11 + NORMAL_LAT || result !== 32'd3) begin
      errors++;
      $display("FAIL kill_restart: c%0d result %h, required c%0d result 00000003",
               doneCyc, result, 11 + NORMAL_LAT);
    end
  endtask

  // Kill during DONE swallows the pulse; kill with valid in IDLE is refused.
  task automatic test_kill_edges();
    @(negedge i_Clock);
    i_Valid = 1'b1; i_Op = DIVOP_DIVU; i_Dividend = 32'd5; i_Divisor = 32'd0;
    @(posedge i_Clock);
    #1 i_Valid = 1'b0;
    i_Kill = 1'b1;
    @(negedge i_Clock);
    checks++;
    if (o_Done !== 1'b0 || o_Ready !== 1'b0) begin
      errors++;
      $display("FAIL kill_in_done: done=%b ready=%b, required 0 0", o_Done, o_Ready);
    end
    @(posedge i_Clock);
    #1 i_Kill = 1'b0;
    @(negedge i_Clock);
    checks++;
    if (o_Ready !== 1'b1 || o_Done !== 1'b0) begin
      errors++;
      $display("FAIL kill_in_done_after: ready=%b done=%b, required 1 0", o_Ready, o_Done);
    end
    i_Valid = 1'b1; i_Kill = 1'b1; i_Op = DIVOP_DIVU; i_Dividend = 32'd100; i_Divisor = 32'd7;
    @(posedge i_Clock);
    #1 begin i_Valid = 1'b0; i_Kill = 1'b0; end
    @(negedge i_Clock);
    checks++;
    if (o_Ready !== 1'b1 || o_AluOwn !== 1'b0) begin
      errors++;
      $display("FAIL kill_valid_idle: ready=%b own=%b, required 1 0", o_Ready, o_AluOwn);
    end
  endtask

  // Two ops with no gap; result holds in the idle cycle between them.
  task automatic test_back_to_back();
    int          doneCyc;
    logic [31:0] result;
    logic        sawOwn, badCtrl, readyAtDone;
    run_op(DIVOP_REMU, 32'd100, 32'd7, doneCyc, result, sawOwn, badCtrl, readyAtDone);
    checks++;
    if (doneCyc != NORMAL_LAT || result !== 32'd2) begin
      errors++;
      $display("FAIL b2b_first: c%0d result %h, required c%0d result 00000002", doneCyc, result, NORMAL_LAT);
    end
    @(negedge i_Clock);
    checks++;
    if (o_Result !== 32'd2 || o_Ready !== 1'b1 || o_Done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_hold: result %h ready %b done %b, required 00000002 1 0", o_Result, o_Ready, o_Done);
    end
    run_op(DIVOP_DIV, 32'd9, 32'hFFFFFFFD, doneCyc, result, sawOwn, badCtrl, readyAtDone);
    checks++;
    if (doneCyc != NORMAL_LAT || result !== 32'hFFFFFFFD) begin
      errors++;
      $display("FAIL b2b_second: c%0d result %h, required c%0d result fffffffd", doneCyc, result, NORMAL_LAT);
    end
  endtask

  initial begin
    i_Reset    = 1'b1;
    i_Valid    = 1'b0;
    i_Kill     = 1'b0;
    i_Op       = 2'b00;
    i_Dividend = '0;
    i_Divisor  = '0;
    test_reset();
    test_divide();
    test_special();
    test_kill(32'hFFFFFFFB);
    test_kill_edges();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
